// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file writeback arbiter: one hold slot per requester,
// round-robin grant onto a registered single write port, plus a pending scoreboard.
module regfile_wr_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [5:0]  a_rd,
    input  logic [31:0] a_val,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [5:0]  b_rd,
    input  logic [31:0] b_val,
    output logic        wr_enable,
    output logic [5:0]  wr_rd,
    output logic [31:0] wr_val,
    input  logic [5:0]  rs1,
    input  logic [5:0]  rs2,
    output logic        rs1_pending,
    output logic        rs2_pending
);

    localparam logic [0:0] GRANT_A = 1'b0;
    localparam logic [0:0] GRANT_B = 1'b1;

    logic        r_hold_a_full;
    logic [5:0]  r_hold_a_rd;
    logic [31:0] r_hold_a_val;
    logic        r_hold_b_full;
    logic [5:0]  r_hold_b_rd;
    logic [31:0] r_hold_b_val;
    logic [0:0]  r_last_grant;
    logic        r_wr_enable;
    logic [5:0]  r_wr_rd;
    logic [31:0] r_wr_val;

    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_take_a;
    logic        w_take_b;

    // When both holds are full, the requester that did not win last time goes first.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_hold_a_full && r_hold_b_full) begin
            w_grant_a = (r_last_grant == GRANT_B);
            w_grant_b = (r_last_grant == GRANT_A);
        end else begin
            w_grant_a = r_hold_a_full;
            w_grant_b = r_hold_b_full;
        end
    end

    assign a_ready  = !r_hold_a_full || w_grant_a;
    assign b_ready  = !r_hold_b_full || w_grant_b;
    assign w_take_a = a_valid && a_ready;
    assign w_take_b = b_valid && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_a_full <= 1'b0;
            r_hold_a_rd   <= '0;
            r_hold_a_val  <= '0;
        end else if (w_take_a) begin
            r_hold_a_full <= 1'b1;
            r_hold_a_rd   <= a_rd;
            r_hold_a_val  <= a_val;
        end else if (w_grant_a) begin
            r_hold_a_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_b_full <= 1'b0;
            r_hold_b_rd   <= '0;
            r_hold_b_val  <= '0;
        end else if (w_take_b) begin
            r_hold_b_full <= 1'b1;
            r_hold_b_rd   <= b_rd;
            r_hold_b_val  <= b_val;
        end else if (w_grant_b) begin
            r_hold_b_full <= 1'b0;
        end
    end

    // Write index/data keep their last values between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_enable  <= 1'b0;
            r_wr_rd      <= '0;
            r_wr_val     <= '0;
            r_last_grant <= GRANT_B;
        end else if (w_grant_a) begin
            r_wr_enable  <= 1'b1;
            r_wr_rd      <= r_hold_a_rd;
            r_wr_val     <= r_hold_a_val;
            r_last_grant <= GRANT_A;
        end else if (w_grant_b) begin
            r_wr_enable  <= 1'b1;
            r_wr_rd      <= r_hold_b_rd;
            r_wr_val     <= r_hold_b_val;
            r_last_grant <= GRANT_B;
        end else begin
            r_wr_enable  <= 1'b0;
        end
    end

    assign wr_enable = r_wr_enable;
    assign wr_rd     = r_wr_rd;
    assign wr_val    = r_wr_val;

    assign rs1_pending = (r_hold_a_full && (r_hold_a_rd == rs1)) ||
                         (r_hold_b_full && (r_hold_b_rd == rs1)) ||
                         (r_wr_enable   && (r_wr_rd     == rs1));
    assign rs2_pending = (r_hold_a_full && (r_hold_a_rd == rs2)) ||
                         (r_hold_b_full && (r_hold_b_rd == rs2)) ||
                         (r_wr_enable   && (r_wr_rd     == rs2));

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: a_valid  input  1  requester A (ALU writeback) has a write.
REQ-005 SHALL provide port: a_ready  output  1  A write accepted this cycle when a_valid high.
REQ-006 SHALL provide port: a_rd  input  6  A destination register index.
REQ-007 SHALL provide port: a_val  input  32  A write data.
REQ-008 SHALL provide ports b_valid, b_ready, b_rd and b_val for requester B (load writeback), with directions, widths and meanings identical to those of A.
REQ-009 SHALL provide port: wr_enable  output  1  register-bench write strobe, one cycle per write.
REQ-010 SHALL provide port: wr_rd  output  6  register-bench write index.
REQ-011 SHALL provide port: wr_val  output  32  register-bench write data.
REQ-012 SHALL provide port: rs1  input  6  scoreboard query index 1.
REQ-013 SHALL provide port: rs2  input  6  scoreboard query index 2.
REQ-014 SHALL provide port: rs1_pending  output  1  write to rs1 is held or in flight.
REQ-015 SHALL provide port: rs2_pending  output  1  write to rs2 is held or in flight.

Function
REQ-016 SHALL hold one entry per requester (hold_x_full, hold_x_rd, hold_x_val); a transfer SHALL occur when x_valid and x_ready are both high at a rising edge, loading the hold.
REQ-017 SHALL drive x_ready = !hold_x_full || grant_x, where grant_x is the current-cycle combinational grant.
REQ-018 SHALL compute grants combinationally: exactly one full hold -> grant it; both full -> grant the requester not in last_grant; none full -> no grant.
REQ-019 SHALL, on each rising edge with a grant, register wr_enable=1 and the granted wr_rd/wr_val, clear the granted hold (unless it is refilled in the same edge), and set last_grant to the granted requester.
REQ-020 SHALL register wr_enable=0 on any edge without a grant; wr_rd/wr_val SHALL hold their previous values.
REQ-021 SHALL give latency: transfer at edge E0, earliest wr_enable high from E1 to E2, data committed by the register bench at E2.
REQ-022 SHALL sustain one write per cycle per requester when uncontended; under contention each requester SHALL wait at most one grant.
REQ-023 SHALL preserve per-requester write order; no ordering is guaranteed between A and B, even for equal rd.
REQ-024 SHALL forward rd=0 like any other index; data SHALL be passed unmodified at 32 bits.
REQ-025 SHALL drive rsN_pending = (hold_a_full && hold_a_rd==rsN) || (hold_b_full && hold_b_rd==rsN) || (wr_enable && wr_rd==rsN), purely combinational.
REQ-026 SHALL ignore x_rd/x_val whenever x_valid is low.

Reset
REQ-027 SHALL, while rst_n is low, force both holds empty, wr_enable=0, wr_rd=0, wr_val=0 and last_grant=B, so that A wins the first contention.
REQ-028 SHALL, on reset assertion mid-operation, discard held and in-flight writes immediately; a_ready/b_ready SHALL be 1 one cycle after rst_n deasserts.

Verification
REQ-029 SHALL be verified by: A only, rd=6, val=11 at E0 -> wr_enable=1, wr_rd=6, wr_val=11 for exactly the E1-E2 cycle; rs1=6 gives rs1_pending=1 from E0 to E2.
REQ-030 SHALL be verified by: A (rd 7, 255) and B (rd 3, 9) transferred in the same cycle -> A written at E1, B at E2; last_grant=B afterwards.
REQ-031 SHALL be verified by: A and B both valid for 6 cycles -> wr_enable high in every cycle with strict A/B alternation, and no loss or duplication.
REQ-032 SHALL be verified by: A streaming rd 1,2,3 back-to-back with B idle -> a_ready stays 1 and writes appear in order on consecutive cycles.
REQ-033 SHALL be verified by: rst_n pulsed low while both holds are full -> no wr_enable pulse for the discarded writes, and all outputs match REQ-027.
REQ-034 SHALL be verified by: A and B both write rd=5 -> two wr_enable pulses, and rs2=5 gives rs2_pending=1 until the second pulse ends.
